mips_dmem_arb: RTL

- Arbiter sharing the single-port data memory between two requesters: the MIPS32 pipeline MEM stage (CPU) and a loader/debug port (LDR) that preloads or inspects data memory.
- Replaces hierarchical data-memory pokes by benches and boot logic.
- Sits between the MEM stage, the loader, and the data memory instance.
- Produces a CPU stall when the CPU loses arbitration.

---
 rtl/mips_dmem_arb.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/mips_dmem_arb.sv
// mips_dmem_arb: shares the single-port data memory between the MIPS32 MEM
// stage (CPU) and a loader/debug port (LDR). The CPU normally wins. A loader
// that has been denied STARVE_MAX cycles in a row is forced through, and the
// CPU stalls for that cycle. Read data comes back one cycle after the grant,
// steered to whichever requester issued the read.
module mips_dmem_arb #(
    parameter int AW         = 10,
    parameter int DW         = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic          clk_x,
    input  logic          rst,

    // CPU (MEM stage) request port
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_gnt,
    output logic          cpu_stall,
    output logic          cpu_rvalid,
    output logic [DW-1:0] cpu_rdata,

    // Loader / debug request port
    input  logic          ldr_req,
    input  logic          ldr_we,
    input  logic [AW-1:0] ldr_addr,
    input  logic [DW-1:0] ldr_wdata,
    output logic          ldr_gnt,
    output logic          ldr_rvalid,
    output logic [DW-1:0] ldr_rdata,

    // Data memory command port
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    localparam int CW = $clog2(STARVE_MAX + 1);
    localparam logic [CW-1:0] STARVE_LIMIT = CW'(STARVE_MAX);

    // Which requester the read data arriving this cycle belongs to.
    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CPU  = 2'd1,
        OWN_LDR  = 2'd2
    } owner_t;

    logic [CW-1:0] starve_cnt;
    logic [CW-1:0] starve_nxt;
    owner_t        owner_q;
    owner_t        owner_nxt;
    logic          force_ldr;
    logic [DW-1:0] cpu_rdata_q;
    logic [DW-1:0] ldr_rdata_q;

    // Arbitration: starved loader first, then CPU, then loader; nothing while in reset.
    always_comb begin
        // NOTE: every output of a combinational block gets a default before
        // any branch, so no path can leave it unassigned and infer a latch.
        cpu_gnt   = 1'b0;
        ldr_gnt   = 1'b0;
        force_ldr = ldr_req && (starve_cnt == STARVE_LIMIT);
        if (rst) begin
            if (force_ldr) begin
                ldr_gnt = 1'b1;
            end else if (cpu_req) begin
                cpu_gnt = 1'b1;
            end else if (ldr_req) begin
                ldr_gnt = 1'b1;
            end
        end
        cpu_stall = cpu_req && !cpu_gnt;
    end

    // Memory command mux: the winner's fields, otherwise an idle command
    // that still presents the CPU address/data.
    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = cpu_addr;
        mem_wdata = cpu_wdata;
        if (ldr_gnt) begin
            mem_en    = 1'b1;
            mem_we    = ldr_we;
            mem_addr  = ldr_addr;
            mem_wdata = ldr_wdata;
        end else if (cpu_gnt) begin
            mem_en    = 1'b1;
            mem_we    = cpu_we;
        end
    end

    // Starvation counter: counts consecutive denied loader cycles, saturating.
    always_comb begin
        starve_nxt = starve_cnt;
        if (!ldr_req || ldr_gnt) begin
            starve_nxt = '0;
        end else if (starve_cnt != STARVE_LIMIT) begin
            starve_nxt = starve_cnt + CW'(1);
        end
    end

    // Read-return next state: remember who issued a granted read.
    always_comb begin
        owner_nxt = OWN_NONE;
        if (cpu_gnt && !cpu_we) begin
            owner_nxt = OWN_CPU;
        end else if (ldr_gnt && !ldr_we) begin
            owner_nxt = OWN_LDR;
        end
    end

    // State registers: counter, read owner and the held read-data copies.
    always_ff @(posedge clk_x or negedge rst) begin
        if (!rst) begin
            starve_cnt  <= '0;
            owner_q     <= OWN_NONE;
            cpu_rdata_q <= '0;
            ldr_rdata_q <= '0;
        end else begin
            // NOTE: state is updated with non-blocking assignments so every
            // register samples the pre-edge values regardless of statement order.
            starve_cnt <= starve_nxt;
            owner_q    <= owner_nxt;
            if (owner_q == OWN_CPU) begin
                cpu_rdata_q <= mem_rdata;
            end
            if (owner_q == OWN_LDR) begin
                ldr_rdata_q <= mem_rdata;
            end
        end
    end

    // Read return: the owner sees memory data directly during its pulse and
    // the held copy afterwards, so rdata is valid in the rvalid cycle itself.
    always_comb begin
        cpu_rvalid = (owner_q == OWN_CPU);
        ldr_rvalid = (owner_q == OWN_LDR);
        cpu_rdata  = cpu_rvalid ? mem_rdata : cpu_rdata_q;
        ldr_rdata  = ldr_rvalid ? mem_rdata : ldr_rdata_q;
    end

endmodule
